// File: rtl/regfile_writeback.sv
// Register-file write-port front end: arbitrates ALU/LSU results into an in-order FIFO.
// Drains one registered write per cycle. Optional REGFILE_WB_BYPASS_EN adds a forwarding query port.
module regfile_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_rd,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic                       wb_en,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0]      fwd_raddr,
  output logic                       fwd_hit,
  output logic [DATA_WIDTH-1:0]      fwd_data,
`endif
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [$clog2(DEPTH)+1-1:0] pending_count,
  output logic                       busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;

  logic                  full;
  logic                  empty;
  logic                  lsu_fire;
  logic                  alu_fire;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] push_rd;
  logic [DATA_WIDTH-1:0] push_data;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign lsu_ready = !full;
  assign alu_ready = !full && !lsu_valid;
  assign lsu_fire  = lsu_valid && lsu_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign pop       = wb_en && !empty;

  assign pending_count = count;
  assign busy          = (count != '0) || rf_wen;

  // Select the single enqueue source; LSU wins over ALU.
  always_comb begin
    push      = 1'b0;
    push_rd   = alu_rd;
    push_data = alu_data;
    unique case (1'b1)
      lsu_fire: begin
        push      = 1'b1;
        push_rd   = lsu_rd;
        push_data = lsu_data;
      end
      alu_fire: begin
        push      = 1'b1;
      end
      default: ;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr]   <= push_rd;
      data_q[wptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Output write registers; an x0 entry is popped but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pop) begin
      rf_wen   <= (rd_q[rptr] != '0);
      rf_waddr <= rd_q[rptr];
      rf_wdata <= data_q[rptr];
    end else begin
      rf_wen   <= 1'b0;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic [PW-1:0] fwd_idx;

  // Youngest-match search: output register first, then FIFO head to tail.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (fwd_raddr != '0) begin
      if (rf_wen && (rf_waddr == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wdata;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = rptr + PW'(i);
        if ((CW'(i) < count) && (rd_q[fwd_idx] == fwd_raddr)) begin
          fwd_hit  = 1'b1;
          fwd_data = data_q[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback.
// Define REGFILE_WB_BYPASS_EN to also exercise the forwarding port.
module tb_regfile_writeback;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          wb_en;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [2:0]    pending_count;
  logic          busy;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0] fwd_raddr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] sb[$];

  always #5 clk = ~clk;

  regfile_writeback #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_rd(lsu_rd),
    .lsu_data(lsu_data),
    .wb_en(wb_en),
`ifdef REGFILE_WB_BYPASS_EN
    .fwd_raddr(fwd_raddr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data),
`endif
    .rf_wen(rf_wen),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pending_count(pending_count),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle: compare writes against the scoreboard, then log accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_wen) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_write", {59'd0, rf_waddr}, 64'd0);
        end else begin
          logic [AW+DW-1:0] e;
          e = sb.pop_front();
          check("sb_waddr", {59'd0, rf_waddr}, {59'd0, e[AW+DW-1:DW]});
          check("sb_wdata", {32'd0, rf_wdata}, {32'd0, e[DW-1:0]});
        end
      end
      if (lsu_valid && lsu_ready) begin
        if (lsu_rd != '0) sb.push_back({lsu_rd, lsu_data});
      end else if (alu_valid && alu_ready) begin
        if (alu_rd != '0) sb.push_back({alu_rd, alu_data});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    wb_en = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    fwd_raddr = '0;
`endif
    #12;
    check("rst_wen", rf_wen, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_count", pending_count, 0);
    check("rst_busy", busy, 0);
    check("rst_lsu_ready", lsu_ready, 1);
    check("rst_alu_ready", alu_ready, 1);
    lsu_valid = 1'b1;
    #1;
    check("rst_alu_ready_lsuv", alu_ready, 0);
    lsu_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // single ALU write, 2-edge latency, one-cycle pulse
    wb_en = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    check("single_count", pending_count, 1);
    check("single_wen_early", rf_wen, 0);
    tick();
    check("single_wen", rf_wen, 1);
    check("single_waddr", rf_waddr, 5);
    check("single_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    check("single_wen_off", rf_wen, 0);
    check("single_busy", busy, 0);

    // simultaneous producers
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    #1;
    check("both_alu_ready", alu_ready, 0);
    check("both_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 1'b0;
    #1;
    check("both_alu_ready2", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check("both_w1_wen", rf_wen, 1);
    check("both_w1_addr", rf_waddr, 1);
    tick();
    check("both_w2_wen", rf_wen, 1);
    check("both_w2_addr", rf_waddr, 2);
    tick();
    check("both_idle", rf_wen, 0);

    // fill with backpressure
    wb_en = 1'b0;
    lsu_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      lsu_rd = AW'(8 + k);
      lsu_data = 32'hA000 + 32'(k);
      tick();
    end
    lsu_valid = 1'b0;
    check("fill_count", pending_count, 4);
    check("fill_lsu_ready", lsu_ready, 0);
    check("fill_wen", rf_wen, 0);
    wb_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_wen", rf_wen, 1);
      check("drain_addr", rf_waddr, 64'(8 + k));
      check("drain_count", pending_count, 64'(3 - k));
    end
    tick();
    check("drain_done", busy, 0);

    // x0 suppression
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    tick();
    lsu_rd = 5'd3; lsu_data = 32'h33;
    tick();
    lsu_valid = 1'b0;
    check("x0_wen", rf_wen, 0);
    check("x0_count", pending_count, 1);
    tick();
    check("x3_wen", rf_wen, 1);
    check("x3_addr", rf_waddr, 3);
    check("x3_data", rf_wdata, 32'h33);
    tick();

    // reset mid-drain
    wb_en = 1'b0;
    lsu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lsu_rd = AW'(4 + k);
      lsu_data = 32'hB000 + 32'(k);
      tick();
    end
    lsu_valid = 1'b0;
    check("mid_count", pending_count, 3);
    wb_en = 1'b1;
    tick();
    check("mid_wen", rf_wen, 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_wen", rf_wen, 0);
    check("mid_rst_count", pending_count, 0);
    check("mid_rst_busy", busy, 0);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_wen", rf_wen, 0);
    end

`ifdef REGFILE_WB_BYPASS_EN
    wb_en = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'd1;
    tick();
    lsu_data = 32'd2;
    tick();
    lsu_valid = 1'b0;
    fwd_raddr = 5'd7;
    #1;
    check("fwd7_hit", fwd_hit, 1);
    check("fwd7_data", fwd_data, 2);
    fwd_raddr = 5'd0;
    #1;
    check("fwd0_hit", fwd_hit, 0);
    check("fwd0_data", fwd_data, 0);
    fwd_raddr = 5'd9;
    #1;
    check("fwd9_hit", fwd_hit, 0);
    wb_en = 1'b1;
    tick();
    tick();
    tick();
    tick();
`endif

    check("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
